piso_tx: RTL and testbench

Parallel-in/serial-out transmitter. It takes a WIDTH-bit word from the parallel register stage on a load handshake and shifts it out one bit per enabled clock, LSB first, with valid and last-bit markers. It is the serial output end paired with the team's parallel `dff` storage register: it drains the word that register captures, one bit at a time.

---
 rtl/piso_tx_pkg.sv | 12 +
 rtl/piso_shreg.sv | 23 ++
 rtl/piso_tx.sv | 118 +++++++++++
 tb/tb_piso_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// piso_tx shared types: control FSM state encoding.
package piso_tx_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit load/shift-right register with synchronous clear.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter, LSB first, with valid/last markers.
// Define PISO_TX_PARITY_EN to append an even-parity bit to each frame.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             load_i,
    output logic             ready_o,
    input  logic             en_i,
    output logic             q_o,
    output logic             q_valid_o,
    output logic             last_o
);
    import piso_tx_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             step;
    logic             data_last;

    assign accept    = (state == IDLE) && load_i;
    assign step      = (state == SHIFT) && en_i;
    assign data_last = (state == SHIFT) && (cnt == CNT_LAST);

    piso_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk  (clk_i),
        .clr  (rst_i),
        .load (accept),
        .shift(step),
        .d    (d_i),
        .q    (shreg)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter stops at the last bit; the state exit makes wrap unnecessary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (step && !data_last) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef PISO_TX_PARITY_EN
    logic par;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^d_i;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        q_valid_o = 1'b0;
        q_o       = 1'b0;
        last_o    = 1'b0;
        unique case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (load_i) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                q_valid_o = 1'b1;
                q_o       = shreg[0];
`ifdef PISO_TX_PARITY_EN
                if (en_i && data_last) begin
                    state_nxt = PARITY;
                end
`else
                last_o = data_last;
                if (en_i && data_last) begin
                    state_nxt = IDLE;
                end
`endif
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                q_valid_o = 1'b1;
                q_o       = par;
                last_o    = 1'b1;
                if (en_i) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: expected bits queued at load, checked as emitted.
module tb_piso_tx;

    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic         en;
    logic [W-1:0] d;
    logic         ready;
    logic         q;
    logic         q_valid;
    logic         last;

    int vectors     = 0;
    int miscompares = 0;

    // Each entry is {bit, last}.
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    piso_tx #(
        .WIDTH(W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .d_i      (d),
        .load_i   (load),
        .ready_o  (ready),
        .en_i     (en),
        .q_o      (q),
        .q_valid_o(q_valid),
        .last_o   (last)
    );

    task automatic push_frame(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            exp_q.push_back({w[i], ((i == W - 1) && !PAR)});
        end
        if (PAR) begin
            exp_q.push_back({^w, 1'b1});
        end
    endtask

    task automatic load_word(input logic [W-1:0] w);
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_load: got %b want 1", ready);
        end
        d    = w;
        load = 1'b1;
        push_frame(w);
        @(posedge clk);
        #1;
        load = 1'b0;
        d    = W'($urandom);
    endtask

    task automatic drain(input bit toggle, input int inj_at,
                         input int abort_at, input string name);
        int         popped = 0;
        int         cyc    = 0;
        bit         injected = 1'b0;
        logic [1:0] e;
        en = 1'b0;
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            load = 1'b0;
            if (abort_at >= 0 && popped == abort_at) begin
                rst = 1'b1;
                en  = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                en  = 1'b0;
                vectors++;
                if (q_valid !== 1'b0 || ready !== 1'b1 || q !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s abort: got valid=%b ready=%b q=%b want 0 1 0",
                             name, q_valid, ready, q);
                end
                exp_q.delete();
                return;
            end
            e = exp_q[0];
            vectors++;
            if (q_valid !== 1'b1 || ready !== 1'b0 ||
                q !== e[1] || last !== e[0]) begin
                miscompares++;
                $display("FAIL %s bit %0d: got valid=%b ready=%b q=%b last=%b want 1 0 %b %b",
                         name, popped, q_valid, ready, q, last, e[1], e[0]);
            end
            if (inj_at >= 0 && popped == inj_at && !injected) begin
                load     = 1'b1;
                d        = '1;
                injected = 1'b1;
            end
            en = toggle ? ~en : 1'b1;
            if (en) begin
                void'(exp_q.pop_front());
                popped++;
            end
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: %0d bits left want 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        load = 1'b0;
        en   = 1'b0;
        vectors++;
        if (ready !== 1'b1 || q_valid !== 1'b0 || last !== 1'b0 || q !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: got ready=%b valid=%b last=%b q=%b want 1 0 0 0",
                     name, ready, q_valid, last, q);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        load = 1'b1;
        en   = 1'b0;
        d    = 8'hff;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (ready !== 1'b1 || q_valid !== 1'b0 || q !== 1'b0 || last !== 1'b0) begin
                miscompares++;
                $display("FAIL reset: got ready=%b valid=%b q=%b last=%b want 1 0 0 0",
                         ready, q_valid, q, last);
            end
        end
    endtask

    task automatic test_basic();
        load_word(8'haa);
        drain(1'b0, -1, -1, "basic");
    endtask

    task automatic test_throttled();
        load_word(8'h55);
        drain(1'b1, -1, -1, "throttled");
    endtask

    task automatic test_ignored_load();
        load_word(8'haa);
        drain(1'b0, 3, -1, "ignored_load");
        @(negedge clk);
        vectors++;
        if (q_valid !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_load idle: got valid=%b ready=%b want 0 1",
                     q_valid, ready);
        end
    endtask

    task automatic test_abort();
        load_word(8'hc3);
        drain(1'b0, -1, 4, "abort");
        load_word(8'h01);
        drain(1'b0, -1, -1, "after_abort");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            load_word(W'($urandom));
            drain(k[0], -1, -1, "back_to_back");
        end
    endtask

`ifdef PISO_TX_PARITY_EN
    task automatic test_parity();
        load_word(8'h07);
        drain(1'b0, -1, -1, "parity_07");
        load_word(8'h03);
        drain(1'b1, -1, -1, "parity_03");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_throttled();
        test_ignored_load();
        test_abort();
        test_back_to_back();
`ifdef PISO_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
